// File: rtl/wave_meter_if.sv
// Bundles the sample stream going into the wave meter and the measurement
// results coming out. The producer takes the master side; the meter takes
// the slave side.
interface wave_meter_if #(
   parameter int W  = 14,
   parameter int CW = 24
);
   logic signed [W-1:0]  sample;
   logic                 val_in;
   logic                 clr;
   logic [CW-1:0]        period;
   logic signed [W-1:0]  max_val;
   logic signed [W-1:0]  min_val;
   logic                 val_out;
   logic                 locked;
   logic                 ovf;

   modport master (
      output sample, val_in, clr,
      input  period, max_val, min_val, val_out, locked, ovf
   );

   modport slave (
      input  sample, val_in, clr,
      output period, max_val, min_val, val_out, locked, ovf
   );
endinterface

// File: rtl/wave_meter.sv
// Wave meter: measures the period (in valid samples) and the signed peak
// values of a periodic waveform. A cycle boundary is a rising crossing of
// zero that was preceded by a dip below -H, which gives hysteresis against
// noise around zero. Three pipeline stages: input capture, measurement
// core, result registers. A crossing captured on edge N shows up on
// val_out after edge N+2.
module wave_meter #(
   parameter int W  = 14,
   parameter int CW = 24,
   parameter int H  = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   wave_meter_if.slave  bus
);

   localparam logic [0:0] SEEK = 1'b0;
   localparam logic [0:0] MEAS = 1'b1;

   localparam int                 NEG_H_I = -H;
   localparam logic signed [W-1:0] NEG_H  = NEG_H_I[W-1:0];
   localparam logic [CW-1:0]      CNT_MAX = '1;
   localparam logic [CW-1:0]      CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   // input capture stage
   logic signed [W-1:0] s_reg;
   logic                v_reg;
   logic                c_reg;

   // measurement core
   logic [0:0]          state_reg, state_next;
   logic                arm_reg, arm_next;
   logic [CW-1:0]       cnt_reg, cnt_next;
   logic signed [W-1:0] run_max_reg, run_max_next;
   logic signed [W-1:0] run_min_reg, run_min_next;
   logic [CW-1:0]       pend_period_reg, pend_period_next;
   logic signed [W-1:0] pend_max_reg, pend_max_next;
   logic signed [W-1:0] pend_min_reg, pend_min_next;
   logic                done_reg, done_next;
   logic                locked_reg, locked_next;
   logic                ovf_reg, ovf_next;

   // result registers
   logic [CW-1:0]       period_reg;
   logic signed [W-1:0] max_out_reg;
   logic signed [W-1:0] min_out_reg;
   logic                val_out_reg;
   logic                locked_out_reg;
   logic                ovf_out_reg;

   logic                crossing;

   // Register the raw input pins before any decision is made on them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg <= '0;
         v_reg <= 1'b0;
         c_reg <= 1'b0;
      end else begin
         s_reg <= bus.sample;
         v_reg <= bus.val_in;
         c_reg <= bus.clr;
      end
   end

   // Next-state logic: arming, crossing detection, counting and extrema.
   always_comb begin
      state_next       = state_reg;
      arm_next         = arm_reg;
      cnt_next         = cnt_reg;
      run_max_next     = run_max_reg;
      run_min_next     = run_min_reg;
      pend_period_next = pend_period_reg;
      pend_max_next    = pend_max_reg;
      pend_min_next    = pend_min_reg;
      locked_next      = locked_reg;
      ovf_next         = ovf_reg;
      done_next        = 1'b0;

      // non-negative sample after a sufficiently deep dip
      crossing = v_reg && arm_reg && !s_reg[W-1];

      if (c_reg) begin
         // restart wins over anything the discarded sample would have done
         state_next  = SEEK;
         arm_next    = 1'b0;
         cnt_next    = '0;
         locked_next = 1'b0;
         ovf_next    = 1'b0;
      end else if (v_reg) begin
         if (crossing) begin
            arm_next = 1'b0;
         end else if (s_reg < NEG_H) begin
            arm_next = 1'b1;
         end

         if (state_reg == SEEK) begin
            if (crossing) begin
               state_next   = MEAS;
               cnt_next     = CNT_ONE;
               run_max_next = s_reg;
               run_min_next = s_reg;
            end
         end else begin
            if (crossing) begin
               // close the cycle; the crossing sample opens the next one
               pend_period_next = cnt_reg;
               pend_max_next    = run_max_reg;
               pend_min_next    = run_min_reg;
               done_next        = 1'b1;
               locked_next      = 1'b1;
               cnt_next         = CNT_ONE;
               run_max_next     = s_reg;
               run_min_next     = s_reg;
            end else if (cnt_reg == CNT_MAX) begin
               // counter would wrap: abandon this cycle and look again
               ovf_next   = 1'b1;
               state_next = SEEK;
               arm_next   = 1'b0;
               cnt_next   = '0;
            end else begin
               cnt_next     = cnt_reg + CNT_ONE;
               run_max_next = (s_reg > run_max_reg) ? s_reg : run_max_reg;
               run_min_next = (s_reg < run_min_reg) ? s_reg : run_min_reg;
            end
         end
      end
   end

   // Measurement core state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= SEEK;
         arm_reg         <= 1'b0;
         cnt_reg         <= '0;
         run_max_reg     <= '0;
         run_min_reg     <= '0;
         pend_period_reg <= '0;
         pend_max_reg    <= '0;
         pend_min_reg    <= '0;
         done_reg        <= 1'b0;
         locked_reg      <= 1'b0;
         ovf_reg         <= 1'b0;
      end else begin
         state_reg       <= state_next;
         arm_reg         <= arm_next;
         cnt_reg         <= cnt_next;
         run_max_reg     <= run_max_next;
         run_min_reg     <= run_min_next;
         pend_period_reg <= pend_period_next;
         pend_max_reg    <= pend_max_next;
         pend_min_reg    <= pend_min_next;
         done_reg        <= done_next;
         locked_reg      <= locked_next;
         ovf_reg         <= ovf_next;
      end
   end

   // Result registers: load on a completed cycle, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_reg     <= '0;
         max_out_reg    <= '0;
         min_out_reg    <= '0;
         val_out_reg    <= 1'b0;
         locked_out_reg <= 1'b0;
         ovf_out_reg    <= 1'b0;
      end else begin
         val_out_reg    <= done_reg;
         locked_out_reg <= locked_reg;
         ovf_out_reg    <= ovf_reg;
         if (done_reg) begin
            period_reg  <= pend_period_reg;
            max_out_reg <= pend_max_reg;
            min_out_reg <= pend_min_reg;
         end
      end
   end

   assign bus.period  = period_reg;
   assign bus.max_val = max_out_reg;
   assign bus.min_val = min_out_reg;
   assign bus.val_out = val_out_reg;
   assign bus.locked  = locked_out_reg;
   assign bus.ovf     = ovf_out_reg;

endmodule

// File: tb/tb_wave_meter.sv
// Bench for wave_meter. Two instances share one stimulus stream: the
// default configuration and an 8-bit counter build that can be driven
// into overflow. A reference model works on the history of valid samples
// (cycle = slice of history between crossings) and queues expected pulses
// and flag values; a negedge monitor pops and compares.
module tb_wave_meter;

   localparam int W = 14;
   localparam int H = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   wave_meter_if #(.W(W), .CW(24)) bus0 ();
   wave_meter_if #(.W(W), .CW(8))  bus1 ();

   wave_meter #(.W(W), .CW(24), .H(H)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   wave_meter #(.W(W), .CW(8),  .H(H)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct { int cyc; int per; int mx; int mn; } exp_t;
   typedef struct { int cyc; bit lk; bit ov; } flg_t;

   exp_t eq0[$], eq1[$];
   flg_t fq0[$], fq1[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulses0 = 0;

   // reference model state
   int  hist[$];
   int  lim[2] = '{16777215, 255};
   int  m_start[2];
   bit  m_meas[2], m_arm[2], m_lock[2], m_ovf[2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, req);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_meas[i] = 0; m_arm[i] = 0; m_lock[i] = 0; m_ovf[i] = 0; m_start[i] = 0;
      end
   endtask

   task automatic model_step(input int s, input bit v, input bit c);
      int   idx, mx, mn;
      bit   cr;
      exp_t e;
      flg_t f;
      if (c) begin
         model_clear();
      end else if (v) begin
         hist.push_back(s);
         idx = hist.size() - 1;
         for (int i = 0; i < 2; i++) begin
            cr = m_arm[i] && (s >= 0);
            if (m_meas[i] && !cr && (idx - m_start[i]) == lim[i]) begin
               m_ovf[i] = 1; m_meas[i] = 0; m_arm[i] = 0;
            end else if (cr) begin
               if (m_meas[i]) begin
                  mx = hist[m_start[i]]; mn = hist[m_start[i]];
                  for (int k = m_start[i]; k < idx; k++) begin
                     if (hist[k] > mx) mx = hist[k];
                     if (hist[k] < mn) mn = hist[k];
                  end
                  e.cyc = cyc + 3; e.per = idx - m_start[i]; e.mx = mx; e.mn = mn;
                  if (i == 0) eq0.push_back(e); else eq1.push_back(e);
                  m_lock[i] = 1;
               end
               m_meas[i] = 1; m_start[i] = idx; m_arm[i] = 0;
            end else if (s < -H) begin
               m_arm[i] = 1;
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         f.cyc = cyc + 3; f.lk = m_lock[i]; f.ov = m_ovf[i];
         if (i == 0) fq0.push_back(f); else fq1.push_back(f);
      end
   endtask

   task automatic drive(input int s, input bit v, input bit c);
      @(posedge clk);
      #1;
      bus0.sample = 14'(s); bus1.sample = 14'(s);
      bus0.val_in = v;      bus1.val_in = v;
      bus0.clr    = c;      bus1.clr    = c;
      model_step(s, v, c);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(0, 1'b0, 1'b0);
   endtask

   function automatic int sine(input int k);
      real x;
      x = 8000.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 100.0);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
   endfunction

   task automatic chk(input int i, input bit vo, input int per, input int mx,
                      input int mn, input bit lk, input bit ov);
      exp_t e;
      flg_t f;
      bit   have;
      // pulses the model expected earlier than now were missed
      have = (i == 0) ? (eq0.size() > 0) : (eq1.size() > 0);
      if (have) begin
         e = (i == 0) ? eq0[0] : eq1[0];
         if (e.cyc < cyc) begin
            if (i == 0) void'(eq0.pop_front()); else void'(eq1.pop_front());
            checks++; failures++;
            $display("FAIL pulse_missed inst=%0d cyc=%0d got val_out=0 required 1 at cyc=%0d", i, cyc, e.cyc);
         end
      end
      if (vo) begin
         if (i == 0) pulses0++;
         have = (i == 0) ? (eq0.size() > 0) : (eq1.size() > 0);
         checks++;
         if (!have) begin
            failures++;
            $display("FAIL pulse_unexpected inst=%0d cyc=%0d got val_out=1 required 0", i, cyc);
         end else begin
            if (i == 0) e = eq0.pop_front(); else e = eq1.pop_front();
            $display("pulse inst=%0d cyc=%0d period=%0d max=%0d min=%0d", i, cyc, per, mx, mn);
            if (e.cyc != cyc || e.per != per || e.mx != mx || e.mn != mn) begin
               failures++;
               $display("FAIL pulse_result inst=%0d got cyc=%0d per=%0d max=%0d min=%0d required cyc=%0d per=%0d max=%0d min=%0d",
                        i, cyc, per, mx, mn, e.cyc, e.per, e.mx, e.mn);
            end
         end
      end
      have = (i == 0) ? (fq0.size() > 0) : (fq1.size() > 0);
      if (have) begin
         f = (i == 0) ? fq0[0] : fq1[0];
         if (f.cyc <= cyc) begin
            if (i == 0) void'(fq0.pop_front()); else void'(fq1.pop_front());
            checks++;
            if (f.lk != lk || f.ov != ov) begin
               failures++;
               $display("FAIL flags inst=%0d cyc=%0d got locked=%0b ovf=%0b required locked=%0b ovf=%0b",
                        i, cyc, lk, ov, f.lk, f.ov);
            end
         end
      end
   endtask

   // Monitor: compare outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk(0, bus0.val_out, int'(bus0.period), int'(bus0.max_val), int'(bus0.min_val),
             bus0.locked, bus0.ovf);
         chk(1, bus1.val_out, int'(bus1.period), int'(bus1.max_val), int'(bus1.min_val),
             bus1.locked, bus1.ovf);
      end
   end

   task automatic check_zero(input string tag);
      cmp({tag, "_period"},  int'(bus0.period), 0);
      cmp({tag, "_max"},     int'(bus0.max_val), 0);
      cmp({tag, "_min"},     int'(bus0.min_val), 0);
      cmp({tag, "_val_out"}, int'(bus0.val_out), 0);
      cmp({tag, "_locked"},  int'(bus0.locked), 0);
      cmp({tag, "_ovf"},     int'(bus1.ovf), 0);
   endtask

   initial begin
      int p;
      int s;
      bit v, c;
      bus0.sample = '0; bus0.val_in = 1'b0; bus0.clr = 1'b0;
      bus1.sample = '0; bus1.val_in = 1'b0; bus1.clr = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #2;
      check_zero("reset");
      rst_n = 1'b1;

      // continuous sine, 5 cycles: three complete periods measured
      p = pulses0;
      for (int k = 0; k < 500; k++) drive(sine(k), 1'b1, 1'b0);
      idle(4);
      cmp("sine_pulses", pulses0 - p, 3);
      cmp("sine_period", int'(bus0.period), 100);
      cmp("sine_max", int'(bus0.max_val), 8000);
      cmp("sine_min", int'(bus0.min_val), -8000);
      cmp("sine_locked", int'(bus0.locked), 1);

      // same sine with a bubble after every valid sample
      for (int k = 0; k < 500; k++) begin
         drive(sine(k), 1'b1, 1'b0);
         drive(int'($urandom_range(0, 16383)) - 8192, 1'b0, 1'b0);
      end
      idle(4);
      cmp("gap_period", int'(bus0.period), 100);

      // small-amplitude noise never arms
      drive(0, 1'b0, 1'b1);
      p = pulses0;
      for (int k = 0; k < 40; k++) drive((k % 2 == 0) ? 10 : -10, 1'b1, 1'b0);
      idle(4);
      cmp("noise_locked", int'(bus0.locked), 0);
      cmp("noise_pulses", pulses0 - p, 0);
      drive(-17, 1'b1, 1'b0);
      drive(0, 1'b1, 1'b0);
      for (int k = 0; k < 30; k++) drive(5, 1'b1, 1'b0);
      drive(-17, 1'b1, 1'b0);
      drive(0, 1'b1, 1'b0);
      idle(4);
      cmp("edge_period", int'(bus0.period), 32);
      cmp("edge_max", int'(bus0.max_val), 5);
      cmp("edge_min", int'(bus0.min_val), -17);

      // counter overflow on the 8-bit instance
      drive(0, 1'b0, 1'b1);
      drive(-20, 1'b1, 1'b0);
      drive(0, 1'b1, 1'b0);
      for (int k = 0; k < 260; k++) drive(0, 1'b1, 1'b0);
      idle(4);
      cmp("ovf_small", int'(bus1.ovf), 1);
      cmp("ovf_big", int'(bus0.ovf), 0);
      drive(-20, 1'b1, 1'b0);
      drive(0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) drive(10, 1'b1, 1'b0);
      drive(-20, 1'b1, 1'b0);
      drive(0, 1'b1, 1'b0);
      idle(4);
      cmp("ovf_sticky", int'(bus1.ovf), 1);
      cmp("ovf_relock_period", int'(bus1.period), 5);
      drive(0, 1'b0, 1'b1);
      idle(4);
      cmp("ovf_clr", int'(bus1.ovf), 0);

      // asynchronous reset in the middle of a measurement
      for (int k = 0; k < 250; k++) drive(sine(k), 1'b1, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus0.val_in = 1'b0; bus1.val_in = 1'b0;
      bus0.clr = 1'b0;    bus1.clr = 1'b0;
      #1;
      check_zero("midreset");
      eq0.delete(); eq1.delete(); fq0.delete(); fq1.delete();
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      p = pulses0;
      for (int k = 0; k < 250; k++) drive(sine(k + 50), 1'b1, 1'b0);
      idle(4);
      cmp("reset_first_pulses", pulses0 - p, 1);

      // clear coinciding with a crossing
      drive(0, 1'b0, 1'b1);
      for (int k = 0; k < 200; k++) drive(sine(k), 1'b1, 1'b0);
      p = pulses0;
      drive(sine(200), 1'b1, 1'b1);
      for (int k = 201; k < 350; k++) drive(sine(k), 1'b1, 1'b0);
      idle(4);
      cmp("clrx_pulses", pulses0 - p, 0);
      cmp("clrx_locked", int'(bus0.locked), 0);

      // random traffic
      for (int k = 0; k < 1500; k++) begin
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) s = int'($urandom_range(0, 16383)) - 8192;
         else s = int'($urandom_range(0, 120)) - 60;
         drive(s, v, c);
      end
      idle(6);
      cmp("queue_left0", eq0.size(), 0);
      cmp("queue_left1", eq1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wave_meter.md
WAVE_METER -- requirements
Module: wave_meter

Interface
REQ-001 Parameter W, default 14: sample width, two's complement.
REQ-002 Parameter CW, default 24: period counter and period output width.
REQ-003 Parameter H, default 16: hysteresis threshold, positive, below 2^(W-1).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 sample  in  W  signed input sample, e.g. DDS sin_wave/ramp_wave.
REQ-007 val_in  in  1  sample qualifier; high means sample is valid this cycle.
REQ-008 clr  in  1  synchronous measurement restart.
REQ-009 period  out  CW  registered count of valid samples in the last full cycle.
REQ-010 max_val  out  W  registered signed maximum over the last full cycle.
REQ-011 min_val  out  W  registered signed minimum over the last full cycle.
REQ-012 val_out  out  1  one-cycle pulse when period/max_val/min_val update.
REQ-013 locked  out  1  high after the first completed measurement, until the next restart.
REQ-014 ovf  out  1  sticky counter-overflow flag.

Function
REQ-015 The block shall register sample, val_in and clr at the input; all rules below apply to these registered copies.
REQ-016 Samples with val_in=0 shall be ignored: no counter, extremum, arm or state change.
REQ-017 The arm flag shall set on a valid sample where sample < -H.
REQ-018 A crossing is a valid sample where arm=1 and sample >= 0; arm shall clear on the same edge.
REQ-019 Samples in [-H, -1] shall neither arm nor trigger; noise below H therefore yields no crossing.
REQ-020 States: SEEK (no reference crossing yet) and MEAS (counting since the last crossing).
REQ-021 SEEK, crossing -> MEAS; cnt=1; run_max=run_min=sample.
REQ-022 MEAS, valid non-crossing sample -> cnt+1; run_max=max(run_max,sample); run_min=min(run_min,sample).
REQ-023 MEAS, crossing -> load period=cnt, max_val=run_max, min_val=run_min; pulse val_out; set locked; restart with cnt=1 and run_max=run_min=sample; remain in MEAS.
REQ-024 The crossing sample shall open the new cycle and shall be excluded from the cycle it closes.
REQ-025 Latency: val_out high in the cycle beginning 2 clk edges after the edge that captures the crossing sample on the input pins; it shall be high for exactly 1 cycle.
REQ-026 period, max_val and min_val shall hold their values between val_out pulses.
REQ-027 Overflow: in MEAS, when cnt=2^CW-1 and a valid non-crossing sample arrives -> set ovf; go to SEEK; clear arm; no val_out pulse.
REQ-028 Comparisons shall be signed; cnt shall not wrap.
REQ-029 clr=1 -> SEEK; clear arm, cnt and locked; ovf clears; the sample captured with clr is discarded.
REQ-030 clr shall take priority over a simultaneous crossing or overflow.
REQ-031 Back-to-back valid samples every cycle shall be supported with no stall.

Reset
REQ-032 While rst_n=0: state=SEEK; arm=0; cnt=0; input registers=0; period=0; max_val=0; min_val=0; val_out=0; locked=0; ovf=0.
REQ-033 Reset asserted mid-measurement shall abort it with no val_out pulse; after release the block waits for a fresh arm and crossing.
REQ-034 Deassertion of rst_n is assumed synchronised externally to clk.

Verification
REQ-035 Sine input, 100 valid samples per cycle, peak +/-8000, val_in=1 continuously, 5 cycles -> from the 2nd crossing on, val_out every 100 clk, period=100, max_val=8000, min_val=-8000, locked=1 after the first pulse.
REQ-036 Same sine with val_in low every other cycle -> period=100 (valid samples only), pulses every 200 clk.
REQ-037 Samples alternating +10/-10 (below H=16) -> no val_out, locked stays 0; then one -17 followed by 0 -> a crossing enters MEAS.
REQ-038 CW=8; arm, cross, then hold 0 for 260 valid samples -> ovf=1 after the 255th count, state SEEK, no val_out; ovf remains 1 until clr.
REQ-039 rst_n pulsed low mid-cycle during REQ-035 stimulus -> all outputs 0 immediately (async); the first pulse after release comes only after two new crossings.
REQ-040 clr asserted on the same cycle as a crossing -> no val_out; locked=0; measurement restarts from SEEK.
